// File: rtl/ysyx_23060025_axi_wr_slave_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_axi_wr_slave_if
// Purpose : AXI4 write-channel bundle (AW, W, B) between the data-cache write
//           buffer (master) and the write-side memory slave.
// Signals : awaddr_i/awvalid_i/awready_o/awlen_i/awsize_i  address channel
//           wdata_i/wstrb_i/wvalid_i/wready_o/wlast_i      data channel
//           bvalid_o/bready_i/bresp_o                      response channel
//           The _i/_o suffixes are seen from the slave side.
// ----------------------------------------------------------------------------
interface ysyx_23060025_axi_wr_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr_i;
   logic                    awvalid_i;
   logic                    awready_o;
   logic [7:0]              awlen_i;
   logic [2:0]              awsize_i;
   logic [DATA_WIDTH-1:0]   wdata_i;
   logic [DATA_WIDTH/8-1:0] wstrb_i;
   logic                    wvalid_i;
   logic                    wready_o;
   logic                    wlast_i;
   logic                    bvalid_o;
   logic                    bready_i;
   logic [1:0]              bresp_o;

   modport master (
      output awaddr_i, awvalid_i, awlen_i, awsize_i,
      output wdata_i, wstrb_i, wvalid_i, wlast_i,
      output bready_i,
      input  awready_o, wready_o, bvalid_o, bresp_o
   );

   modport slave (
      input  awaddr_i, awvalid_i, awlen_i, awsize_i,
      input  wdata_i, wstrb_i, wvalid_i, wlast_i,
      input  bready_i,
      output awready_o, wready_o, bvalid_o, bresp_o
   );
endinterface

// File: rtl/ysyx_23060025_axi_wr_slave.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_axi_wr_slave
// Purpose : AXI4 write slave backed by a word-addressed SRAM. Accepts one
//           AW/W transaction at a time (single strobed writes or INCR bursts),
//           returns OKAY / SLVERR (wlast vs awlen disagreement) / DECERR
//           (any beat outside the memory window) on the B channel.
// Ports   : clock, reset      single clock, synchronous active-high reset
//           bus               AW/W/B channels (slave modport)
//           dbg_raddr_i       debug word index
//           dbg_rdata_o       memory word at dbg_raddr_i (combinational)
// ----------------------------------------------------------------------------
module ysyx_23060025_axi_wr_slave #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    MEM_DEPTH_W = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000),
   parameter int                    WAIT_CYCLES = 0
) (
   input  logic                          clock,
   input  logic                          reset,
   ysyx_23060025_axi_wr_slave_if.slave   bus,
   input  logic [MEM_DEPTH_W-1:0]        dbg_raddr_i,
   output logic [DATA_WIDTH-1:0]         dbg_rdata_o
);

   localparam int         LANES         = DATA_WIDTH / 8;
   localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DATA = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   cur_addr_r;
   logic [7:0]              len_r;
   logic [7:0]              beat_cnt_r;
   logic [3:0]              wait_cnt_r;
   logic                    err_slv_r;
   logic                    err_dec_r;
   logic                    awready_r;
   logic                    wready_r;
   logic                    bvalid_r;
   logic [1:0]              bresp_r;

   logic [DATA_WIDTH-1:0]   mem_r [2**MEM_DEPTH_W];

   logic [ADDR_WIDTH-1:0]   offset_s;
   logic                    in_range_s;
   logic [MEM_DEPTH_W-1:0]  word_idx_s;
   logic                    beat_s;
   logic                    we_s;
   logic                    dec_next_s;
   logic                    slv_next_s;
   logic                    unused_s;

   // DECERR outranks SLVERR; both outrank OKAY.
   function automatic logic [1:0] resp_enc(input logic dec, input logic slv);
      logic [1:0] r;
      if (dec) begin
         r = 2'b11;
      end else if (slv) begin
         r = 2'b10;
      end else begin
         r = 2'b00;
      end
      return r;
   endfunction

   // Decode of the current beat: window check, word index and updated error flags.
   always_comb begin
      offset_s   = cur_addr_r - BASE_ADDR;
      // Window is 4*2^MEM_DEPTH_W bytes: every offset bit above that must be zero.
      in_range_s = ((offset_s >> (MEM_DEPTH_W + 2)) == '0);
      word_idx_s = offset_s[MEM_DEPTH_W+1:2];
      beat_s     = (state_r == ST_DATA) && wready_r && bus.wvalid_i;
      we_s       = beat_s && in_range_s && !reset;
      dec_next_s = err_dec_r | ~in_range_s;
      // Malformed burst: wlast on a beat other than len, or len reached without wlast.
      slv_next_s = err_slv_r | ((beat_cnt_r == len_r) != bus.wlast_i);
   end

   // Low address bits and awsize do not affect a word-granular, always-+4 INCR slave.
   assign unused_s = ^{offset_s[1:0], bus.awsize_i};

   // Transaction FSM with registered handshake/response outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cur_addr_r <= '0;
         len_r      <= 8'd0;
         beat_cnt_r <= 8'd0;
         wait_cnt_r <= 4'd0;
         err_slv_r  <= 1'b0;
         err_dec_r  <= 1'b0;
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         bvalid_r   <= 1'b0;
         bresp_r    <= 2'b00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               awready_r <= 1'b1;
               if (bus.awvalid_i && awready_r) begin
                  cur_addr_r <= bus.awaddr_i;
                  len_r      <= bus.awlen_i;
                  beat_cnt_r <= 8'd0;
                  err_slv_r  <= 1'b0;
                  err_dec_r  <= 1'b0;
                  wait_cnt_r <= WAIT_CNT_INIT;
                  awready_r  <= 1'b0;
                  if (WAIT_CYCLES > 0) begin
                     state_r <= ST_WAIT;
                  end else begin
                     state_r  <= ST_DATA;
                     wready_r <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               wait_cnt_r <= wait_cnt_r - 4'd1;
               if (wait_cnt_r <= 4'd1) begin
                  state_r  <= ST_DATA;
                  wready_r <= 1'b1;
               end
            end
            ST_DATA: begin
               if (beat_s) begin
                  cur_addr_r <= cur_addr_r + ADDR_WIDTH'(4);
                  beat_cnt_r <= beat_cnt_r + 8'd1;
                  err_dec_r  <= dec_next_s;
                  err_slv_r  <= slv_next_s;
                  if (bus.wlast_i) begin
                     state_r  <= ST_RESP;
                     wready_r <= 1'b0;
                     bvalid_r <= 1'b1;
                     bresp_r  <= resp_enc(dec_next_s, slv_next_s);
                  end
               end
            end
            ST_RESP: begin
               if (bus.bready_i) begin
                  state_r   <= ST_IDLE;
                  bvalid_r  <= 1'b0;
                  bresp_r   <= 2'b00;
                  awready_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               awready_r <= 1'b0;
               wready_r  <= 1'b0;
               bvalid_r  <= 1'b0;
               bresp_r   <= 2'b00;
            end
         endcase
      end
   end

   // SRAM write port: byte lanes gated by wstrb; contents survive reset.
   always_ff @(posedge clock) begin
      if (we_s) begin
         for (int k = 0; k < LANES; k++) begin
            if (bus.wstrb_i[k]) begin
               mem_r[word_idx_s][8*k +: 8] <= bus.wdata_i[8*k +: 8];
            end
         end
      end
   end

   assign dbg_rdata_o   = mem_r[dbg_raddr_i];
   assign bus.awready_o = awready_r;
   assign bus.wready_o  = wready_r;
   assign bus.bvalid_o  = bvalid_r;
   assign bus.bresp_o   = bresp_r;

endmodule

// File: tb/tb_ysyx_23060025_axi_wr_slave.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060025_axi_wr_slave
// Directed bench: u_dut0 has no wait states, u_dut3 has WAIT_CYCLES=3.
// Expected B responses go into a queue when a transaction is driven and are
// popped when bvalid is seen; memory contents are checked against a byte-lane
// model through the debug read port.
// ----------------------------------------------------------------------------
module tb_ysyx_23060025_axi_wr_slave;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  dbg_a0, dbg_a3;
   logic [31:0] dbg_d0, dbg_d3;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [1:0]  exp_q [$];
   logic [31:0] mdl [1024];
   logic [31:0] bd [8];
   logic [3:0]  bs [8];
   logic        bl [8];

   always #5 clk = ~clk;

   ysyx_23060025_axi_wr_slave_if bus0 ();
   ysyx_23060025_axi_wr_slave_if bus3 ();

   ysyx_23060025_axi_wr_slave #(.WAIT_CYCLES(0)) u_dut0 (
      .clock(clk), .reset(rst), .bus(bus0),
      .dbg_raddr_i(dbg_a0), .dbg_rdata_o(dbg_d0)
   );

   ysyx_23060025_axi_wr_slave #(.WAIT_CYCLES(3)) u_dut3 (
      .clock(clk), .reset(rst), .bus(bus3),
      .dbg_raddr_i(dbg_a3), .dbg_rdata_o(dbg_d3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mem_chk(input int idx);
      dbg_a0 = 10'(idx);
      #1;
      chk($sformatf("mem[%0d]", idx), dbg_d0, mdl[idx]);
   endtask

   task automatic model_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] off;
      off = a - BASE;
      if (off < 32'd4096) begin
         for (int k = 0; k < 4; k++) begin
            if (s[k]) mdl[off[11:2]][8*k +: 8] = d[8*k +: 8];
         end
      end
   endtask

   // Full transaction on u_dut0 using beats bd/bs/bl[0..n-1].
   task automatic burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                        input int n, input logic [1:0] er);
      int          t;
      logic [31:0] a;
      exp_q.push_back(er);
      bus0.awaddr_i  = addr;
      bus0.awlen_i   = len;
      bus0.awsize_i  = size;
      bus0.awvalid_i = 1'b1;
      t = 0;
      while (bus0.awready_o !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      chk("aw_ready_timeout", 32'(t < 20), 32'd1);
      tick();
      bus0.awvalid_i = 1'b0;
      chk("awready_low_in_burst", 32'(bus0.awready_o), 32'd0);
      a = addr;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("wready_beat%0d", i), 32'(bus0.wready_o), 32'd1);
         bus0.wdata_i  = bd[i];
         bus0.wstrb_i  = bs[i];
         bus0.wlast_i  = bl[i];
         bus0.wvalid_i = 1'b1;
         tick();
         model_beat(a, bd[i], bs[i]);
         a = a + 32'd4;
      end
      bus0.wvalid_i = 1'b0;
      bus0.wlast_i  = 1'b0;
      chk("bvalid_after_last", 32'(bus0.bvalid_o), 32'd1);
      chk("bresp", 32'(bus0.bresp_o), 32'(exp_q.pop_front()));
      bus0.bready_i = 1'b1;
      tick();
      bus0.bready_i = 1'b0;
      chk("awready_after_b", 32'(bus0.awready_o), 32'd1);
      chk("bvalid_cleared", 32'(bus0.bvalid_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      rst = 1'b1;
      dbg_a0 = 10'd0; dbg_a3 = 10'd0;
      bus0.awaddr_i = 32'd0; bus0.awvalid_i = 1'b0; bus0.awlen_i = 8'd0; bus0.awsize_i = 3'd2;
      bus0.wdata_i = 32'd0; bus0.wstrb_i = 4'd0; bus0.wvalid_i = 1'b0; bus0.wlast_i = 1'b0;
      bus0.bready_i = 1'b0;
      bus3.awaddr_i = 32'd0; bus3.awvalid_i = 1'b0; bus3.awlen_i = 8'd0; bus3.awsize_i = 3'd2;
      bus3.wdata_i = 32'd0; bus3.wstrb_i = 4'd0; bus3.wvalid_i = 1'b0; bus3.wlast_i = 1'b0;
      bus3.bready_i = 1'b0;
      tick(); tick(); tick();

      // Reset state
      chk("rst_awready0", 32'(bus0.awready_o), 32'd0);
      chk("rst_wready0",  32'(bus0.wready_o),  32'd0);
      chk("rst_bvalid0",  32'(bus0.bvalid_o),  32'd0);
      chk("rst_bresp0",   32'(bus0.bresp_o),   32'd0);
      chk("rst_awready3", 32'(bus3.awready_o), 32'd0);
      chk("rst_bvalid3",  32'(bus3.bvalid_o),  32'd0);
      rst = 1'b0;
      tick();
      chk("idle_awready0", 32'(bus0.awready_o), 32'd1);

      // Preload word 0 and word 1020 so stray writes there become visible
      bd[0] = 32'hC0DE_0000; bs[0] = 4'hF; bl[0] = 1'b1;
      burst(32'h8000_0000, 8'd0, 3'd2, 1, 2'b00);
      mem_chk(0);
      bd[0] = 32'hA5A5_5A5A;
      burst(32'h8000_0FF0, 8'd0, 3'd2, 1, 2'b00);
      mem_chk(1020);

      // Single word write
      bd[0] = 32'hDEAD_BEEF;
      burst(32'h8000_0010, 8'd0, 3'd2, 1, 2'b00);
      mem_chk(4);

      // Byte write into lane 2
      bd[0] = 32'h00AB_0000; bs[0] = 4'h4;
      burst(32'h8000_0012, 8'd0, 3'd0, 1, 2'b00);
      dbg_a0 = 10'd4;
      #1;
      chk("byte_write_word4", dbg_d0, 32'hDEAB_BEEF);

      // wstrb=0 beat: no write, OKAY
      bd[0] = 32'h1234_5678; bs[0] = 4'h0;
      burst(32'h8000_0010, 8'd0, 3'd2, 1, 2'b00);
      mem_chk(4);

      // Cacheline INCR burst
      for (int i = 0; i < 4; i++) begin
         bd[i] = 32'h1111_1111 * (i + 1);
         bs[i] = 4'hF;
         bl[i] = (i == 3);
      end
      burst(32'h8000_0020, 8'd3, 3'd2, 4, 2'b00);
      for (int i = 8; i < 12; i++) mem_chk(i);

      // Below the window: DECERR, nothing written (word 1020 aliases the offset)
      bd[0] = 32'hFFFF_FFFF; bs[0] = 4'hF; bl[0] = 1'b1;
      burst(32'h7FFF_FFF0, 8'd0, 3'd2, 1, 2'b11);
      mem_chk(1020);
      mem_chk(4);

      // Burst crossing the window top: last word written, DECERR, no wrap to word 0
      bd[0] = 32'h1234_5678; bd[1] = 32'h9ABC_DEF0;
      bs[0] = 4'hF; bs[1] = 4'hF; bl[0] = 1'b0; bl[1] = 1'b1;
      burst(32'h8000_0FFC, 8'd1, 3'd2, 2, 2'b11);
      mem_chk(1023);
      mem_chk(0);

      // awlen 3, wlast on beat 1: SLVERR
      bd[0] = 32'hAAAA_0001; bd[1] = 32'hAAAA_0002;
      burst(32'h8000_0030, 8'd3, 3'd2, 2, 2'b10);
      mem_chk(12);
      mem_chk(13);

      // awlen 0, wlast only on beat 1: SLVERR, both beats written
      bd[0] = 32'hBBBB_0001; bd[1] = 32'hBBBB_0002;
      burst(32'h8000_0038, 8'd0, 3'd2, 2, 2'b10);
      mem_chk(14);
      mem_chk(15);

      // Reset in the middle of a burst
      bus0.awaddr_i = 32'h8000_0040; bus0.awlen_i = 8'd3; bus0.awvalid_i = 1'b1;
      tick();
      bus0.awvalid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus0.wdata_i = 32'h5555_0000 + 32'(i); bus0.wstrb_i = 4'hF;
         bus0.wlast_i = 1'b0; bus0.wvalid_i = 1'b1;
         tick();
         model_beat(32'h8000_0040 + 32'(4 * i), 32'h5555_0000 + 32'(i), 4'hF);
      end
      bus0.wvalid_i = 1'b0;
      rst = 1'b1;
      tick(); tick();
      chk("midrst_awready", 32'(bus0.awready_o), 32'd0);
      chk("midrst_wready",  32'(bus0.wready_o),  32'd0);
      chk("midrst_bvalid",  32'(bus0.bvalid_o),  32'd0);
      rst = 1'b0;
      tick();
      chk("postrst_awready", 32'(bus0.awready_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("postrst_no_bvalid", 32'(bus0.bvalid_o), 32'd0);
         tick();
      end
      mem_chk(16);
      mem_chk(17);
      bd[0] = 32'h7777_8888; bs[0] = 4'hF; bl[0] = 1'b1;
      burst(32'h8000_0048, 8'd0, 3'd2, 1, 2'b00);
      mem_chk(18);

      // WAIT_CYCLES=3 instance, awlen 1 with a single wlast beat, bready held low
      exp_q.push_back(2'b10);
      bus3.awaddr_i = 32'h8000_0080; bus3.awlen_i = 8'd1; bus3.awvalid_i = 1'b1;
      t = 0;
      while (bus3.awready_o !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      chk("w3_aw_ready_timeout", 32'(t < 20), 32'd1);
      tick();
      bus3.awvalid_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("w3_wready_T+%0d", c), 32'(bus3.wready_o), 32'd0);
         chk($sformatf("w3_awready_T+%0d", c), 32'(bus3.awready_o), 32'd0);
         chk($sformatf("w3_bvalid_T+%0d", c), 32'(bus3.bvalid_o), 32'd0);
         tick();
      end
      chk("w3_wready_T+4", 32'(bus3.wready_o), 32'd1);
      bus3.wdata_i = 32'hCAFE_F00D; bus3.wstrb_i = 4'hF; bus3.wlast_i = 1'b1; bus3.wvalid_i = 1'b1;
      tick();
      bus3.wvalid_i = 1'b0; bus3.wlast_i = 1'b0;
      chk("w3_bvalid", 32'(bus3.bvalid_o), 32'd1);
      chk("w3_bresp", 32'(bus3.bresp_o), 32'(exp_q.pop_front()));
      for (int c = 0; c < 5; c++) begin
         chk("w3_bvalid_hold", 32'(bus3.bvalid_o), 32'd1);
         chk("w3_bresp_hold", 32'(bus3.bresp_o), 32'd2);
         tick();
      end
      bus3.bready_i = 1'b1;
      tick();
      bus3.bready_i = 1'b0;
      chk("w3_awready_after_b", 32'(bus3.awready_o), 32'd1);
      chk("w3_bvalid_cleared", 32'(bus3.bvalid_o), 32'd0);
      dbg_a3 = 10'd32;
      #1;
      chk("w3_mem32", dbg_d3, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
